matrix_result_reader: RTL and testbench
=======================================

// Module: matrix_result_reader
// PURPOSE
//  Drain side of the matrix_mul datapath. Captures a completed flattened NxN result
//  bus into a 2-bank ping-pong buffer, then streams it out one element per beat.
//  Order is row-major, on a valid/ready handshake with row/col tags and an end-of-matrix
//  flag. While one matrix is being streamed out, the next result can be captured.
// PARAMETERS
//  DATA_WIDTH   8  bits per matrix element
//  MATRIX_SIZE  3  N, matrix is NxN; legal range N>=1
//  (IW = (MATRIX_SIZE>1) ? $clog2(MATRIX_SIZE) : 1)
// PORTS
//  clock         in   1                 single clock, all logic on posedge
//  reset         in   1                 synchronous, active-high
//  res_valid     in   1                 res_data holds a complete result matrix this cycle
//  res_data      in   N*N*DATA_WIDTH    element (m,n) at [(m*N+n)*DATA_WIDTH +: DATA_WIDTH]
//  res_ready     out  1                 a free bank exists; capture occurs on res_valid&&res_ready
//  out_valid     out  1                 out_data/out_row/out_col/out_last valid
//  out_ready     in   1                 downstream accepts the beat
//  out_data      out  DATA_WIDTH        current element
//  out_row       out  IW                row index m of current element
//  out_col       out  IW                column index n of current element
//  out_last      out  1                 current beat is element (N-1,N-1)
//  overflow_err  out  1                 sticky: res_valid arrived while res_ready=0
// BEHAVIOUR
//  State: banks bank[0..1] (N*N elements each), wr_sel, rd_sel, cnt (0..2), row, col,
//   overflow_err. All state is registered.
//  Reset (sync, has priority over all else): cnt=0, wr_sel=rd_sel=0, row=col=0,
//   overflow_err=0. Bank contents are not reset.
//   Resulting outputs: out_valid=0, res_ready=1, out_last=0, out_row=out_col=0.
//  res_ready = (cnt!=2). Decoded from registers only; no combinational path from out_ready.
//  Capture: on res_valid&&res_ready, bank[wr_sel] <= res_data, wr_sel toggles, cnt+1.
//  Drop: on res_valid&&!res_ready, data is discarded and overflow_err<=1.
//   overflow_err clears only on reset.
//  Output side:
//   out_valid = (cnt!=0); out_data = bank[rd_sel][row*N+col]; out_row=row; out_col=col.
//   out_last = out_valid && row==N-1 && col==N-1.
//  Beat: on out_valid&&out_ready, col increments. When col==N-1, col wraps to 0 and row
//   increments. On the last beat: row=col=0, rd_sel toggles, cnt-1.
//  Stall: while out_valid && !out_ready, all out_* outputs hold stable.
//  Latency: a matrix captured at edge k presents element (0,0) in cycle k+1 when cnt was 0.
//   With out_ready held 1, one beat per cycle; N*N consecutive beats per matrix.
//   Back-to-back matrices stream with no bubble.
//  Simultaneous capture and last beat in one cycle: cnt is unchanged, both wr_sel and rd_sel
//   toggle, and the next beat comes from the new matrix.
//   When cnt==2, capture is refused even if the last beat drains in that cycle.
//  N=1: every beat is last; out_row=out_col=0 always.
//  Reset mid-stream: the partially drained matrix and any queued matrix are discarded.
// TESTING
//  (N=3, DATA_WIDTH=8, element (m,n) = 0x10*(m+1)+(n+1), i.e. 0x11..0x33)
//  1. Reset; 1-cycle res_valid; out_ready=1 -> 9 beats starting the next cycle,
//     0x11,0x12,0x13,0x21..0x33. Row/col tags match; out_last only on 0x33;
//     res_ready stays 1; out_valid=0 after the 9th beat.
//  2. Capture one matrix; out_ready alternates 1,0,1,0.. -> data held stable during stalls;
//     9 beats complete in 17 cycles; no duplicated or skipped element.
//  3. out_ready=0; capture M0 (0x11..) then M1 (M0+0x40) on consecutive cycles
//     -> res_ready=0 afterwards.
//     A third res_valid -> dropped, overflow_err=1.
//     Then out_ready=1 -> 18 beats, M0 then M1, out_last on beats 9 and 18;
//     res_ready=1 after beat 9.
//  4. cnt=1, streaming M0; res_valid with M1 in the same cycle as M0's last beat
//     -> M1 captured, cnt stays 1, next cycle out_data=0x51 (M1 element (0,0)), no gap.
//  5. Mid-stream reset after beat 4 of M0 with M1 queued -> next cycle out_valid=0,
//     res_ready=1, overflow_err=0. A new capture streams from (0,0) with its own data.
//  6. MATRIX_SIZE=1 build: capture 0xA5 -> one beat, out_data=0xA5, out_last=1,
//     out_row=out_col=0.

Source files
------------

// File: rtl/matrix_result_reader.sv
// matrix_result_reader: ping-pong drain buffer for matrix_mul results.
// Captures a full NxN result and streams it row-major on valid/ready.
module matrix_result_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 3,
  localparam int N  = MATRIX_SIZE,
  localparam int NN = N * N,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int AW = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     res_valid,
  input  logic [NN*DATA_WIDTH-1:0] res_data,
  output logic                     res_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [IW-1:0]            out_row,
  output logic [IW-1:0]            out_col,
  output logic                     out_last,
  output logic                     overflow_err
);

  logic [DATA_WIDTH-1:0] mem [2][NN];
  logic                  wr_sel;
  logic                  rd_sel;
  logic [1:0]            cnt;
  logic [IW-1:0]         row;
  logic [IW-1:0]         col;
  logic [AW-1:0]         idx;
  logic                  cap;
  logic                  beat;
  logic                  col_end;
  logic                  row_end;
  logic                  last_beat;

  assign res_ready = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign cap       = res_valid && res_ready;
  assign beat      = out_valid && out_ready;
  assign col_end   = (col == IW'(N - 1));
  assign row_end   = (row == IW'(N - 1));
  assign last_beat = beat && col_end && row_end;

  assign idx      = AW'(row) * AW'(N) + AW'(col);
  assign out_data = mem[rd_sel][idx];
  assign out_row  = row;
  assign out_col  = col;
  assign out_last = out_valid && row_end && col_end;

  // Bank storage: load the whole result into the write bank on capture.
  always_ff @(posedge clock) begin
    if (cap && !reset) begin
      for (int i = 0; i < NN; i++) begin
        mem[wr_sel][i] <= res_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Bank selects and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (cap) wr_sel <= ~wr_sel;
      if (last_beat) rd_sel <= ~rd_sel;
      if (cap && !last_beat) cnt <= cnt + 2'd1;
      else if (!cap && last_beat) cnt <= cnt - 2'd1;
    end
  end

  // Row/column walk through the current read bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (beat) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + IW'(1);
      end else begin
        col <= col + IW'(1);
      end
    end
  end

  // Sticky flag for results offered while both banks are full.
  always_ff @(posedge clock) begin
    if (reset) overflow_err <= 1'b0;
    else if (res_valid && !res_ready) overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb_matrix_result_reader: random traffic vs queue model.
// Also a directed N=1 check on a second instance.
module tb_matrix_result_reader;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int NN = N * N;
  localparam int IW = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic             res_valid;
  logic [NN*DW-1:0] res_data;
  logic             res_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_row;
  logic [IW-1:0]    out_col;
  logic             out_last;
  logic             overflow_err;

  logic          s_res_valid;
  logic [DW-1:0] s_res_data;
  logic          s_res_ready;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [DW-1:0] s_out_data;
  logic [0:0]    s_out_row;
  logic [0:0]    s_out_col;
  logic          s_out_last;
  logic          s_overflow_err;

  matrix_result_reader #(
    .DATA_WIDTH (DW),
    .MATRIX_SIZE(N)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_last    (out_last),
    .overflow_err(overflow_err)
  );

  matrix_result_reader #(
    .DATA_WIDTH (DW),
    .MATRIX_SIZE(1)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .res_valid   (s_res_valid),
    .res_data    (s_res_data),
    .res_ready   (s_res_ready),
    .out_valid   (s_out_valid),
    .out_ready   (s_out_ready),
    .out_data    (s_out_data),
    .out_row     (s_out_row),
    .out_col     (s_out_col),
    .out_last    (s_out_last),
    .overflow_err(s_overflow_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  logic [NN*DW-1:0] q[$];
  int               pos   = 0;
  bit               m_ovf = 1'b0;

  task automatic check_outputs();
    bit v;
    v = (q.size() != 0);
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("res_ready", 32'(res_ready), 32'(q.size() < 2));
    chk("overflow", 32'(overflow_err), 32'(m_ovf));
    if (v) begin
      chk("out_data", 32'(out_data), 32'(q[0][pos*DW +: DW]));
      chk("out_row", 32'(out_row), 32'(pos / N));
      chk("out_col", 32'(out_col), 32'(pos % N));
      chk("out_last", 32'(out_last), 32'(pos == NN - 1));
    end else begin
      chk("out_last_idle", 32'(out_last), 32'(0));
    end
  endtask

  task automatic model_update();
    bit cap;
    if (reset) begin
      q.delete();
      pos   = 0;
      m_ovf = 1'b0;
    end else begin
      cap = res_valid && (q.size() < 2);
      if (res_valid && !cap) m_ovf = 1'b1;
      if (q.size() != 0 && out_ready) begin
        pos++;
        if (pos == NN) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
      if (cap) q.push_back(res_data);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
  endtask

  int pv[4] = '{30, 60, 20, 90};
  int pr[4] = '{100, 50, 80, 30};

  initial begin
    reset       = 1'b1;
    res_valid   = 1'b0;
    res_data    = '0;
    out_ready   = 1'b0;
    s_res_valid = 1'b0;
    s_res_data  = '0;
    s_out_ready = 1'b0;
    cycle();
    cycle();
    @(negedge clock);
    reset = 1'b0;
    check_outputs();
    chk("rst_row", 32'(out_row), 32'(0));
    chk("rst_col", 32'(out_col), 32'(0));
    chk("n1_rst_valid", 32'(s_out_valid), 32'(0));
    chk("n1_rst_ready", 32'(s_res_ready), 32'(1));

    s_res_valid = 1'b1;
    s_res_data  = 8'hA5;
    cycle();
    @(negedge clock);
    s_res_valid = 1'b0;
    chk("n1_valid", 32'(s_out_valid), 32'(1));
    chk("n1_data", 32'(s_out_data), 32'hA5);
    chk("n1_last", 32'(s_out_last), 32'(1));
    chk("n1_row", 32'(s_out_row), 32'(0));
    chk("n1_col", 32'(s_out_col), 32'(0));
    s_out_ready = 1'b1;
    cycle();
    @(negedge clock);
    chk("n1_drained", 32'(s_out_valid), 32'(0));
    chk("n1_ovf", 32'(s_overflow_err), 32'(0));

    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        @(negedge clock);
        check_outputs();
        reset     = ($urandom_range(0, 299) == 0);
        res_valid = ($urandom_range(0, 99) < pv[ph]);
        for (int i = 0; i < NN; i++) begin
          res_data[i*DW +: DW] = DW'($urandom());
        end
        out_ready = ($urandom_range(0, 99) < pr[ph]);
        cycle();
      end
    end
    @(negedge clock);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
